// File: rtl/branch_predictor_btb_if.sv
// ============================================================================
// Module      : branch_predictor_btb_if
// Description : Fetch lookup, EX resolve and flush/redirect bundle of the BTB
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_predictor_btb_if;
  logic [63:0] pc_IF;
  logic [63:0] predicted_pc_IF;
  logic        pred_taken_IF;
  logic        upd_valid;
  logic        upd_is_branch;
  logic [63:0] upd_pc;
  logic        upd_taken;
  logic [63:0] upd_target;
  logic [63:0] upd_pred_pc;
  logic        flush;
  logic [63:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  // Pipeline side: drives fetch PC and resolved-branch reports.
  modport master (
    output pc_IF, upd_valid, upd_is_branch, upd_pc, upd_taken, upd_target, upd_pred_pc,
    input  predicted_pc_IF, pred_taken_IF, flush, redirect_pc, branch_cnt, mispredict_cnt
  );

  // Predictor side.
  modport slave (
    input  pc_IF, upd_valid, upd_is_branch, upd_pc, upd_taken, upd_target, upd_pred_pc,
    output predicted_pc_IF, pred_taken_IF, flush, redirect_pc, branch_cnt, mispredict_cnt
  );
endinterface

`default_nettype wire

// File: rtl/branch_predictor_btb.sv
// ============================================================================
// Module      : branch_predictor_btb
// Description : Direct-mapped BTB with 2-bit counters, EX-stage resolve/flush
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor_btb #(
  parameter int          ENTRIES    = 16,
  parameter int          IDX_W      = 4,
  parameter logic [63:0] PRESET_VAL = 64'd0
) (
  input  wire logic              clk,
  input  wire logic              arst_n,
  branch_predictor_btb_if.slave  bus
);

  localparam int c_TAG_W = 62 - IDX_W;

  logic [ENTRIES-1:0] r_valid;
  logic [c_TAG_W-1:0] r_tag    [ENTRIES];
  logic [63:0]        r_target [ENTRIES];
  logic [1:0]         r_ctr    [ENTRIES];

  logic        r_flush;
  logic [63:0] r_redirect_pc;
  logic [31:0] r_branch_cnt;
  logic [31:0] r_mispredict_cnt;

  logic [IDX_W-1:0]   w_lk_idx;
  logic [c_TAG_W-1:0] w_lk_tag;
  logic               w_lk_hit;
  logic [IDX_W-1:0]   w_up_idx;
  logic [c_TAG_W-1:0] w_up_tag;
  logic               w_up_hit;
  logic               w_up_taken;
  logic [63:0]        w_actual_next;
  logic               w_mispredict;
  logic               w_unused;

  assign w_lk_idx = bus.pc_IF[IDX_W+1:2];
  assign w_lk_tag = bus.pc_IF[63:IDX_W+2];
  assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

  assign bus.pred_taken_IF   = w_lk_hit && r_ctr[w_lk_idx][1];
  assign bus.predicted_pc_IF = bus.pred_taken_IF ? r_target[w_lk_idx] : bus.pc_IF + 64'd4;

  assign w_up_idx      = bus.upd_pc[IDX_W+1:2];
  assign w_up_tag      = bus.upd_pc[63:IDX_W+2];
  assign w_up_hit      = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  assign w_up_taken    = bus.upd_is_branch && bus.upd_taken;
  assign w_actual_next = w_up_taken ? bus.upd_target : bus.upd_pc + 64'd4;
  assign w_mispredict  = bus.upd_valid && (w_actual_next != bus.upd_pred_pc);

  // Byte-offset bits never take part in indexing or tag compare.
  assign w_unused = ^{bus.pc_IF[1:0], bus.upd_pc[1:0]};

  // Valid bits carry the only table reset; a non-branch hitting the table is an alias.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_valid <= '0;
    end else if (bus.upd_valid) begin
      if (bus.upd_is_branch) begin
        if (!w_up_hit && bus.upd_taken) begin
          r_valid[w_up_idx] <= 1'b1;
        end
      end else if (w_up_hit) begin
        r_valid[w_up_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.upd_valid && bus.upd_is_branch) begin
      if (w_up_hit) begin
        if (bus.upd_taken) begin
          r_target[w_up_idx] <= bus.upd_target;
          if (r_ctr[w_up_idx] != 2'b11) begin
            r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'b01;
          end
        end else if (r_ctr[w_up_idx] != 2'b00) begin
          r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'b01;
        end
      end else if (bus.upd_taken) begin
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= bus.upd_target;
        r_ctr[w_up_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_flush          <= 1'b0;
      r_redirect_pc    <= PRESET_VAL;
      r_branch_cnt     <= PRESET_VAL[31:0];
      r_mispredict_cnt <= PRESET_VAL[31:0];
    end else begin
      r_flush <= w_mispredict;
      if (w_mispredict) begin
        r_redirect_pc    <= w_actual_next;
        r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
      end
      if (bus.upd_valid && bus.upd_is_branch) begin
        r_branch_cnt <= r_branch_cnt + 32'd1;
      end
    end
  end

  assign bus.flush          = r_flush;
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.branch_cnt     = r_branch_cnt;
  assign bus.mispredict_cnt = r_mispredict_cnt;

endmodule

`default_nettype wire

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Fetch-side branch predictor: a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Produces the predicted next PC consumed by the IF/ID pipeline register.
- Resolves branches reported from the EX stage and generates the flush/redirect that the IF/ID register and PC logic consume.
- It is the producer of the predicted-PC/flush interface that the pipeline registers receive.

Parameters:
- ENTRIES, 16, number of BTB entries; must be a power of two.
- IDX_W, 4, log2(ENTRIES); index width.
- PRESET_VAL, 0, reset value for redirect_pc and statistics counters.

Ports:
- clk  input  1  clock.
- arst_n  input  1  reset, asynchronous, active-low.
- pc_IF  input  64  PC of the instruction currently being fetched.
- predicted_pc_IF  output  64  predicted next PC for pc_IF.
- pred_taken_IF  output  1  1 = prediction is "taken" (BTB hit with counter[1]=1).
- upd_valid  input  1  EX stage reports a resolved instruction this cycle.
- upd_is_branch  input  1  resolved instruction is a branch or jump.
- upd_pc  input  64  PC of the resolved instruction.
- upd_taken  input  1  actual direction (ignored when upd_is_branch=0).
- upd_target  input  64  actual taken target.
- upd_pred_pc  input  64  predicted next PC carried down the pipeline with the instruction.
- flush  output  1  one-cycle pulse: squash IF/ID and redirect fetch.
- redirect_pc  output  64  correct next PC; valid while flush=1.
- branch_cnt  output  32  resolved branches since reset.
- mispredict_cnt  output  32  mispredictions since reset.

Behaviour:
- Address split:
  - index = pc[IDX_W+1:2].
  - tag = pc[63:IDX_W+2], width 62-IDX_W.
  - pc[1:0] is ignored.
- Entry fields: valid (1), tag, target (64), ctr (2).
- Reset (arst_n=0, asynchronous, effective immediately, including mid-operation):
  - All valid bits cleared.
  - flush=0, redirect_pc=PRESET_VAL, branch_cnt=0, mispredict_cnt=0.
  - ctr and target contents are don't-care.
- Lookup is combinational from table state:
  - hit = valid[idx] && tag[idx]==tag(pc_IF).
  - pred_taken_IF = hit && ctr[idx][1].
  - predicted_pc_IF = pred_taken_IF ? target[idx] : pc_IF+4 (64-bit modulo add; wraps at 2^64).
- Update (sampled at posedge clk when upd_valid=1):
  - actual_next = (upd_is_branch && upd_taken) ? upd_target : upd_pc+4.
  - Branch, hit at upd_pc index:
    - ctr saturating increment if taken (max 2'b11), decrement if not taken (min 2'b00).
    - If taken, target <= upd_target.
  - Branch, miss, taken: allocate (overwrite any existing entry): valid=1, tag, target=upd_target, ctr=2'b10.
  - Branch, miss, not taken: no allocation.
  - Non-branch, hit (alias): valid cleared.
- Mispredict = upd_valid && (actual_next != upd_pred_pc). On the same edge:
  - flush <= 1.
  - redirect_pc <= actual_next.
  - mispredict_cnt += 1.
- Otherwise flush <= 0; redirect_pc holds its last value.
- Flush latency: exactly one cycle after the update is sampled; pulse width is one cycle per mispredict. Mispredicts on back-to-back cycles give back-to-back pulses, each carrying its own redirect_pc.
- branch_cnt increments on every upd_valid && upd_is_branch. Both 32-bit counters wrap silently at 2^32-1 -> 0.
- Simultaneous lookup and update to the same index: lookup returns the pre-update contents; the new contents are visible from the next cycle.
- upd_valid=0: no state change except flush <= 0.
- The predictor does not stall. The pipeline's hazard logic is responsible for holding pc_IF; the lookup simply tracks pc_IF.

Test Plan:
- Reset, then pc_IF=0x100 -> predicted_pc_IF=0x104, pred_taken_IF=0, flush=0, both counters 0.
- Update: pc=0x100, branch, taken, target=0x200, pred_pc=0x104 -> next cycle flush=1, redirect_pc=0x200, mispredict_cnt=1. Following cycle flush=0. Then pc_IF=0x100 -> predicted 0x200, pred_taken_IF=1.
- Same branch resolved not-taken twice with pred_pc=0x200 -> ctr 10->01->00; two flush pulses, redirect_pc=0x104 each; pc_IF=0x100 now predicts 0x104.
- Aliasing: pc 0x100 and 0x140 (ENTRIES=16) share index 0. A taken branch at 0x140 replaces the 0x100 entry. A non-branch update at 0x140 with pred_pc=target -> flush, redirect 0x144, entry invalidated.
- Correct prediction: update with pred_pc equal to actual_next -> flush stays 0; branch_cnt increments; mispredict_cnt unchanged. Also check the 0xFFFF_FFFF -> 0 wrap by forcing the counter.
- Assert arst_n mid-burst while flush=1 -> flush=0 immediately, all lookups miss, counters 0.
